set_counter: RTL and testbench

// - Downstream consumer of the coordinate generator in the SET datapath: takes one (x,y) grid point per

---
 rtl/set_counter_pkg.sv | 41 ++++
 rtl/set_counter_if.sv | 28 ++
 rtl/set_counter_circle_hit.sv | 65 ++++++
 rtl/set_counter.sv | 100 ++++++++++
 tb/tb_set_counter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/set_counter_pkg.sv
// Shared types and constants for the SET point counter.
// Holds job sizing, coordinate field layout, set modes and FSM states.
package set_counter_pkg;

    localparam int NPTS     = 64;
    localparam int CNT_W    = 7;
    localparam int COORD_SZ = 8;
    localparam int X_HI     = 7;
    localparam int X_LO     = 4;
    localparam int Y_HI     = 3;
    localparam int Y_LO     = 0;

    localparam logic [1:0] MODE_A   = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Set relation between the two circle hits for the selected mode.
    function automatic logic sel_fn(
        input logic [1:0] mode,
        input logic       a,
        input logic       b
    );
        logic s;
        case (mode)
            MODE_A:   s = a;
            MODE_AND: s = a & b;
            MODE_XOR: s = a ^ b;
            default:  s = a | b;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/set_counter_if.sv
// Job/point/result bundle of the SET point counter.
// master: job and point source. slave: the counter.
interface set_counter_if;
    import set_counter_pkg::*;

    logic                en_i;
    logic [15:0]         central_i;
    logic [7:0]          radius_i;
    logic [1:0]          mode_i;
    logic                coord_valid_i;
    logic [COORD_SZ-1:0] coord_i;
    logic                busy_o;
    logic                valid_o;
    logic [CNT_W-1:0]    candidate_o;

    modport master (
        output en_i, central_i, radius_i, mode_i,
        output coord_valid_i, coord_i,
        input  busy_o, valid_o, candidate_o
    );

    modport slave (
        input  en_i, central_i, radius_i, mode_i,
        input  coord_valid_i, coord_i,
        output busy_o, valid_o, candidate_o
    );

endinterface

// File: rtl/set_counter_circle_hit.sv
// Two-stage point-in-circle test: S1 offsets, S2 squared distance vs r*r.
// Ports: clk_i, rst_i (sync, active-low), flush, in_valid, x, y, xc, yc, r
//        -> out_valid, hit (2-cycle latency), busy (either stage occupied).
module set_counter_circle_hit (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [3:0] xc,
    input  logic [3:0] yc,
    input  logic [3:0] r,
    output logic       out_valid,
    output logic       hit,
    output logic       busy
);

    logic              v1;
    logic              v2;
    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic [3:0]        ax;
    logic [3:0]        ay;
    logic [7:0]        sx;
    logic [7:0]        sy;
    logic [8:0]        d2;
    logic [7:0]        r2;

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush) begin
            v1 <= 1'b0;
            dx <= '0;
            dy <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                dx <= $signed({1'b0, x}) - $signed({1'b0, xc});
                dy <= $signed({1'b0, y}) - $signed({1'b0, yc});
            end
        end
    end

    // Magnitudes fit in 4 bits (|d| <= 15), so squares are exact in 8 bits.
    assign ax = dx[4] ? 4'(~dx + 5'd1) : dx[3:0];
    assign ay = dy[4] ? 4'(~dy + 5'd1) : dy[3:0];
    assign sx = {4'b0, ax} * {4'b0, ax};
    assign sy = {4'b0, ay} * {4'b0, ay};
    assign d2 = {1'b0, sx} + {1'b0, sy};
    assign r2 = {4'b0, r} * {4'b0, r};

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush) begin
            v2  <= 1'b0;
            hit <= 1'b0;
        end else begin
            v2  <= v1;
            hit <= (d2 <= {1'b0, r2});
        end
    end

    assign out_valid = v2;
    assign busy      = v1 | v2;

endmodule

// File: rtl/set_counter.sv
// Counts grid points of a job lying in the selected A/B circle set relation.
// Ports: clk_i, rst_i (sync, active-low), bus (slave: job, points, result).
module set_counter
    import set_counter_pkg::*;
(
    input logic          clk_i,
    input logic          rst_i,
    set_counter_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] acc;
    logic [15:0]      central;
    logic [7:0]       radius;
    logic [1:0]       mode;
    logic             accept;
    logic             last;
    logic             va;
    logic             vb;
    logic             ha;
    logic             hb;
    logic             ba;
    logic             bb;

    // A point arriving with en_i belongs to neither job and is dropped.
    assign accept = (state == RUN) && bus.coord_valid_i && !bus.en_i;
    assign last   = accept && (cnt == CNT_W'(NPTS - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = IDLE;
            RUN:   if (last) state_nx = DRAIN;
            DRAIN: if (!(ba || bb)) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
        if (bus.en_i) state_nx = RUN;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt     <= '0;
            acc     <= '0;
            central <= '0;
            radius  <= '0;
            mode    <= '0;
        end else if (bus.en_i) begin
            cnt     <= '0;
            acc     <= '0;
            central <= bus.central_i;
            radius  <= bus.radius_i;
            mode    <= bus.mode_i;
        end else begin
            if (accept) cnt <= cnt + CNT_W'(1);
            if (va && vb) acc <= acc + CNT_W'(sel_fn(mode, ha, hb));
        end
    end

    set_counter_circle_hit u_hit_a (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (bus.en_i),
        .in_valid  (accept),
        .x         (bus.coord_i[X_HI:X_LO]),
        .y         (bus.coord_i[Y_HI:Y_LO]),
        .xc        (central[15:12]),
        .yc        (central[11:8]),
        .r         (radius[7:4]),
        .out_valid (va),
        .hit       (ha),
        .busy      (ba)
    );

    set_counter_circle_hit u_hit_b (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (bus.en_i),
        .in_valid  (accept),
        .x         (bus.coord_i[X_HI:X_LO]),
        .y         (bus.coord_i[Y_HI:Y_LO]),
        .xc        (central[7:4]),
        .yc        (central[3:0]),
        .r         (radius[3:0]),
        .out_valid (vb),
        .hit       (hb),
        .busy      (bb)
    );

    assign bus.busy_o      = (state == RUN) || (state == DRAIN);
    assign bus.valid_o     = (state == DONE);
    assign bus.candidate_o = acc;

endmodule

// File: tb/tb_set_counter.sv
// Scoreboard bench for set_counter: jobs push model counts, monitor pops on valid_o.
// Directed circle cases, gaps, dropped/aborted jobs, mid-job reset, random jobs.
module tb_set_counter;
    import set_counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    set_counter_if bus ();

    set_counter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int px[64];
    int py[64];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Set membership straight from geometry over the job's point list.
    function automatic int model(input int xa, ya, xb, yb, ra, rb, md);
        int n = 0;
        for (int i = 0; i < 64; i++) begin
            bit a, b, s;
            a = (px[i]-xa)*(px[i]-xa) + (py[i]-ya)*(py[i]-ya) <= ra*ra;
            b = (px[i]-xb)*(px[i]-xb) + (py[i]-yb)*(py[i]-yb) <= rb*rb;
            case (md)
                0:       s = a;
                1:       s = a && b;
                2:       s = a != b;
                default: s = a || b;
            endcase
            n += int'(s);
        end
        return n;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (bus.valid_o === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else check("count", int'(bus.candidate_o), exp_q.pop_front());
        end
    end

    task automatic fill_grid();
        for (int i = 0; i < 64; i++) begin
            px[i] = i / 8 + 1;
            py[i] = i % 8 + 1;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            px[i] = $urandom_range(15, 0);
            py[i] = $urandom_range(15, 0);
        end
    endtask

    task automatic start_job(input int xa, ya, xb, yb, ra, rb, md, input bit drop);
        @(negedge clk);
        bus.en_i          = 1'b1;
        bus.central_i     = {4'(xa), 4'(ya), 4'(xb), 4'(yb)};
        bus.radius_i      = {4'(ra), 4'(rb)};
        bus.mode_i        = 2'(md);
        bus.coord_valid_i = drop;
        bus.coord_i       = {4'(xa), 4'(ya)};
        @(negedge clk);
        bus.en_i          = 1'b0;
        bus.coord_valid_i = 1'b0;
    endtask

    // Ends on the negedge right after the last point's accepting edge.
    task automatic feed(input int n, input int gmin, input int gmax);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmax, gmin)) begin
                @(negedge clk);
                bus.coord_valid_i = 1'b0;
                bus.coord_i       = 8'($urandom);
            end
            @(negedge clk);
            bus.coord_valid_i = 1'b1;
            bus.coord_i       = {4'(px[i]), 4'(py[i])};
        end
        @(posedge clk);
        @(negedge clk);
        bus.coord_valid_i = 1'b0;
    endtask

    task automatic run_job(input int xa, ya, xb, yb, ra, rb, md,
                           input int gmin, input int gmax, input bit drop);
        exp_q.push_back(model(xa, ya, xb, yb, ra, rb, md));
        start_job(xa, ya, xb, yb, ra, rb, md, drop);
        feed(64, gmin, gmax);
        @(posedge clk); #1;
        check("busy_t1", int'(bus.busy_o), 1);
        @(posedge clk); #1;
        check("valid_t2", int'(bus.valid_o), 0);
        @(posedge clk); #1;
        check("valid_t3", int'(bus.valid_o), 1);
        check("busy_t3", int'(bus.busy_o), 0);
        @(posedge clk); #1;
        check("valid_t4", int'(bus.valid_o), 0);
    endtask

    initial begin
        bus.en_i          = 1'b0;
        bus.central_i     = '0;
        bus.radius_i      = '0;
        bus.mode_i        = '0;
        bus.coord_valid_i = 1'b0;
        bus.coord_i       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_valid", int'(bus.valid_o), 0);
        check("rst_cand", int'(bus.candidate_o), 0);
        @(negedge clk);
        rst = 1'b1;

        fill_grid();
        for (int m = 0; m < 4; m++) run_job(4, 4, 4, 4, 2, 2, m, 0, 0, 0);
        run_job(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_job(4, 4, 0, 0, 15, 0, 0, 0, 0, 0);
        for (int m = 1; m < 4; m++) run_job(2, 4, 6, 4, 2, 2, m, 0, 0, 0);

        run_job(2, 4, 6, 4, 2, 2, 3, 2, 2, 0);
        run_job(4, 4, 4, 4, 2, 2, 0, 0, 3, 0);

        run_job(4, 4, 4, 4, 2, 2, 0, 0, 0, 1);
        run_job(1, 1, 8, 8, 3, 3, 3, 0, 0, 1);

        start_job(3, 3, 5, 5, 4, 4, 3, 0);
        feed(30, 0, 1);
        run_job(2, 4, 6, 4, 2, 2, 2, 0, 1, 0);

        start_job(4, 4, 0, 0, 15, 0, 0, 0);
        feed(64, 0, 0);
        run_job(2, 4, 6, 4, 2, 2, 1, 0, 0, 0);

        start_job(1, 1, 0, 0, 15, 0, 0, 0);
        feed(20, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(bus.busy_o), 0);
        check("midrst_valid", int'(bus.valid_o), 0);
        check("midrst_cand", int'(bus.candidate_o), 0);
        @(negedge clk);
        rst = 1'b1;
        feed(44, 0, 0);
        repeat (8) @(posedge clk);
        run_job(5, 2, 3, 7, 3, 4, 2, 0, 0, 0);

        repeat (8) begin
            fill_rand();
            run_job($urandom_range(15, 0), $urandom_range(15, 0),
                    $urandom_range(15, 0), $urandom_range(15, 0),
                    $urandom_range(15, 0), $urandom_range(15, 0),
                    $urandom_range(3, 0), 0, $urandom_range(2, 0),
                    1'($urandom_range(1, 0)));
        end

        repeat (6) @(posedge clk);
        #1;
        check("pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
